// File: rtl/rv_fetch_unit_if.sv
// Fetch-unit bus bundle: the instruction-memory request/response channel plus
// the decode-side valid/ready channel. The master modport is the fetch unit.
interface rv_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req_valid, imem_addr, instr, pc, instr_valid,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr, pc, instr_valid,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
    );
endinterface

// File: rtl/rv_fetch_unit.sv
// Instruction fetch stage: PC owner, credit-limited in-order memory requests,
// small instruction FIFO to decode, and redirect with wrong-path discard.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the misaligned-target trap output.
module rv_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          CNT_W      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSel,
    input  logic [31:0]     alu_result,
    rv_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misaligned
`endif
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW   = PTR_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [FCW-1:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] data_mem_q [FIFO_DEPTH];
    logic [31:0] pc_mem_q   [FIFO_DEPTH];

    logic        credit_ok, trap_stall, req_valid, accept;
    logic        rsp_keep, push, pop, fifo_nonempty;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign trap_stall = mis_q;
    assign misaligned = mis_q;
`else
    logic unused_low_bits;
    assign unused_low_bits = ^alu_result[1:0];
    assign trap_stall      = 1'b0;
`endif

    assign target        = {alu_result[31:2], 2'b00};
    assign fifo_nonempty = (count_q != '0);
    // In-flight plus buffered words never exceed the FIFO, so responses need no backpressure.
    assign credit_ok = (32'(outstanding_q) + 32'(count_q)) < 32'(FIFO_DEPTH);
    assign req_valid = ~rst & credit_ok & ~PCSel & ~trap_stall;
    assign accept    = req_valid & bus.imem_req_ready;
    assign rsp_keep  = bus.imem_rsp_valid & (drop_q == '0);
    assign push      = rsp_keep & ~PCSel;
    assign pop       = fifo_nonempty & bus.instr_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.instr_valid    = fifo_nonempty;
    assign bus.instr          = fifo_nonempty ? data_mem_q[rd_ptr_q] : 32'h0;
    assign bus.pc             = fifo_nonempty ? pc_mem_q[rd_ptr_q]   : 32'h0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(bus.imem_rsp_valid);
        drop_d        = drop_q;
        count_d       = count_q + FCW'(push) - FCW'(pop);
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_d         = mis_q;
`endif
        if (accept)
            fetch_pc_d = fetch_pc_q + 32'd4;
        if (bus.imem_rsp_valid && drop_q != '0)
            drop_d = drop_q - 1'b1;
        if (rsp_keep)
            rsp_pc_d = rsp_pc_q + 32'd4;
        // Everything still in flight after this cycle belongs to the old path.
        if (PCSel) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = outstanding_q - CNT_W'(bus.imem_rsp_valid);
            fetch_pc_d = target;
            rsp_pc_d   = target;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d      = |alu_result[1:0];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q         <= 1'b0;
`endif
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q         <= mis_d;
`endif
        end
    end

    // Storage is never reset; validity comes solely from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= bus.imem_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Randomized bench for rv_fetch_unit: a queue-based memory plus a reference model
// that tracks in-flight requests (marked wrong-path on redirect) and buffered words.
module tb_rv_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSel;
    logic [31:0] alu_result;
    rv_fetch_unit_if bus ();
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    rv_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSel      (PCSel),
        .alu_result (alu_result),
        .bus        (bus)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned (misaligned)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; bit doomed; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

    req_t        mem_q[$];
    ent_t        fifo_q[$];
    logic [31:0] exp_fetch_pc;
    bit          exp_mis;
    int          cyc;
    int          checks;
    int          errors;
    int          max_extra_lat;
    bit          rsp_always;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0:       t = 32'h0000_0100;
            1:       t = 32'hFFFF_FFF8;
            2:       t = $urandom & 32'hFFFF_FFFC;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    task automatic model_reset();
        mem_q.delete();
        fifo_q.delete();
        exp_fetch_pc = RESET_PC;
        exp_mis      = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_instr", bus.instr, 32'h0);
        check_eq("rst_pc", bus.pc, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("rst_misaligned", 32'(misaligned), 32'd0);
`endif
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model.
    task automatic step(input int pm, input int pd, input int pr,
                        input bit force_redir, input logic [31:0] force_tgt);
        bit   exp_rv, rdy, drdy, rsp;
        ent_t e;
        req_t r;
        rdy  = ($urandom_range(99) < pm);
        drdy = ($urandom_range(99) < pd);
        bus.imem_req_ready = rdy;
        bus.instr_ready    = drdy;
        PCSel      = force_redir ? 1'b1 : ($urandom_range(99) < pr);
        alu_result = force_redir ? force_tgt : pick_target();
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) &&
              (rsp_always || $urandom_range(3) != 0);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? word_of(mem_q[0].addr) : $urandom;
        exp_rv = (mem_q.size() + fifo_q.size() < DEPTH) && !PCSel && !exp_mis;

        @(negedge clk);
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv)
            check_eq("imem_addr", bus.imem_addr, exp_fetch_pc);
        check_eq("instr_valid", 32'(bus.instr_valid), 32'(fifo_q.size() != 0));
        if (fifo_q.size() != 0) begin
            check_eq("pc", bus.pc, fifo_q[0].pc);
            check_eq("instr", bus.instr, fifo_q[0].word);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("misaligned", 32'(misaligned), 32'(exp_mis));
`endif

        if (fifo_q.size() != 0 && drdy)
            void'(fifo_q.pop_front());
        if (rsp) begin
            r = mem_q.pop_front();
            if (!r.doomed && !PCSel) begin
                e.pc   = r.addr;
                e.word = word_of(r.addr);
                fifo_q.push_back(e);
            end
        end
        if (exp_rv && rdy) begin
            r.addr   = exp_fetch_pc;
            r.due    = cyc + 1 + $urandom_range(max_extra_lat);
            r.doomed = 1'b0;
            mem_q.push_back(r);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
        if (PCSel) begin
            fifo_q.delete();
            foreach (mem_q[i]) mem_q[i].doomed = 1'b1;
            exp_fetch_pc = {alu_result[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_mis = |alu_result[1:0];
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        max_extra_lat = 0;
        rsp_always    = 1'b1;
        rst        = 1'b1;
        PCSel      = 1'b0;
        alu_result = 32'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Straight-line fetch, single-cycle memory, decode always ready.
        repeat (40) step(100, 100, 0, 1'b0, 32'h0);
        // Decode backpressure, then release.
        repeat (8)  step(100, 0, 0, 1'b0, 32'h0);
        repeat (20) step(100, 100, 0, 1'b0, 32'h0);
        // Misaligned redirect, aligned redirect, then wrap-around at the top of memory.
        step(100, 100, 0, 1'b1, 32'h0000_0102);
        repeat (10) step(100, 100, 0, 1'b0, 32'h0);
        step(100, 100, 0, 1'b1, 32'h0000_0200);
        repeat (10) step(100, 100, 0, 1'b0, 32'h0);
        step(100, 100, 0, 1'b1, 32'hFFFF_FFF8);
        repeat (10) step(100, 100, 0, 1'b0, 32'h0);

        // Random traffic with variable latency and redirects.
        max_extra_lat = 2;
        rsp_always    = 1'b0;
        repeat (1500) step(70, 70, 8, 1'b0, 32'h0);

        // Asynchronous reset in the middle of traffic; memory is reset alongside.
        #2;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        model_reset();
        bus.imem_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        repeat (500) step(70, 70, 8, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
